// File: rtl/ir_pkg.sv
// ir_pkg: shared state encoding, reading type and channel limit for the IR sample controller
package ir_pkg;
   localparam int IR_MAX_CH = 8;
   localparam int IR_DATA_W = 12;
   typedef logic [IR_DATA_W-1:0] ir_rd_t;
   typedef enum logic [2:0] {IDLE, DARK_REQ, DARK_WAIT, SETTLE, REQ, WAIT, DONE} state_t;
endpackage

// File: rtl/ir_a2d_handshake.sv
// ir_a2d_handshake: one A2D conversion per request state, with timeout abort
module ir_a2d_handshake import ir_pkg::*; #(
   parameter int DATA_W      = IR_DATA_W,
   parameter int CNV_TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              busy,
   input  logic [2:0]        ch,
   input  logic              cnv_cmplt,
   input  logic [DATA_W-1:0] res,
   output logic              strt_cnv,
   output logic [2:0]        chnl,
   output logic              a2d_err,
   output logic              done,
   output logic [DATA_W-1:0] rd
);
   localparam int TW = $clog2(CNV_TIMEOUT + 1);
   // first wait cycle holds 0, so the abort lands CNV_TIMEOUT cycles after strt_cnv
   localparam logic [TW-1:0] TMO_LAST = TW'(CNV_TIMEOUT - 1);
   logic [TW-1:0] tmo;
   always_ff @(posedge clk)
      if (rst || req) tmo <= '0;
      else if (busy) tmo <= tmo + 1'b1;
   assign strt_cnv = req;
   assign chnl     = ch;
   assign done     = busy && cnv_cmplt;
   assign a2d_err  = busy && !cnv_cmplt && tmo == TMO_LAST;
   assign rd       = res;
endmodule

// File: rtl/ir_sample_ctrl.sv
// ir_sample_ctrl: periodic IR channel sweep into a shadow-banked reading store.
// IR_AMBIENT_CANCEL_EN adds a dark pass and stores lit minus dark, clamped at 0.
module ir_sample_ctrl import ir_pkg::*; #(
   parameter int NUM_CH        = 8,
   parameter int DATA_W        = IR_DATA_W,
   parameter int SAMPLE_PERIOD = 50000,
   parameter int SETTLE_CYC    = 256,
   parameter int CNV_TIMEOUT   = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   output logic              strt_cnv,
   output logic [2:0]        chnl,
   input  logic              cnv_cmplt,
   input  logic [DATA_W-1:0] res,
   output logic              IR_en,
   output logic              IR_vld,
   input  logic [2:0]        sel,
   output logic [DATA_W-1:0] IR_val,
   output logic              a2d_err
);
   localparam int PW = $clog2(SAMPLE_PERIOD);
   localparam int SW = $clog2(SETTLE_CYC) + 1;
   localparam logic [PW-1:0] P_LAST  = PW'(SAMPLE_PERIOD - 1);
   localparam logic [SW-1:0] S_LAST  = SW'(SETTLE_CYC - 1);
   localparam logic [2:0]    CH_LAST = 3'(NUM_CH - 1);
   localparam logic [3:0]    N_CH    = 4'(NUM_CH);
`ifdef IR_AMBIENT_CANCEL_EN
   localparam state_t FIRST = DARK_REQ;
`else
   localparam state_t FIRST = SETTLE;
`endif
   state_t state, nxt;
   logic [PW-1:0] timer;
   logic [SW-1:0] settle;
   logic [2:0] ch;
   logic [DATA_W-1:0] work_bank [NUM_CH];
   logic [DATA_W-1:0] out_bank [NUM_CH];
   logic [DATA_W-1:0] rd, wr_val;
   logic done, err, last, wrap;
   assign last = ch == CH_LAST;
   assign wrap = en && timer == P_LAST;
   ir_a2d_handshake #(.DATA_W(DATA_W), .CNV_TIMEOUT(CNV_TIMEOUT)) u_hs (
      .clk(clk),
      .rst(rst),
      .req(en && (state == REQ || state == DARK_REQ)),
      .busy(en && (state == WAIT || state == DARK_WAIT)),
      .ch(ch),
      .cnv_cmplt(cnv_cmplt),
      .res(res),
      .strt_cnv(strt_cnv),
      .chnl(chnl),
      .a2d_err(err),
      .done(done),
      .rd(rd)
   );
   assign a2d_err = err;
   always_comb begin
      nxt = state;
      case (state)
         IDLE:      nxt = wrap ? FIRST : IDLE;
         DARK_REQ:  nxt = DARK_WAIT;
         DARK_WAIT: nxt = !done ? DARK_WAIT : last ? SETTLE : DARK_REQ;
         SETTLE:    nxt = settle == S_LAST ? REQ : SETTLE;
         REQ:       nxt = WAIT;
         WAIT:      nxt = !done ? WAIT : last ? DONE : REQ;
         default:   nxt = IDLE;
      endcase
      if (!en || err) nxt = IDLE;
   end
`ifdef IR_AMBIENT_CANCEL_EN
   logic [DATA_W-1:0] dark_bank [NUM_CH];
   always_ff @(posedge clk)
      if (rst) dark_bank <= '{default: '0};
      else if (done && state == DARK_WAIT) dark_bank[ch] <= rd;
   assign wr_val = rd > dark_bank[ch] ? rd - dark_bank[ch] : '0;
`else
   assign wr_val = rd;
`endif
   always_ff @(posedge clk)
      if (rst) begin
         state     <= IDLE;
         timer     <= '0;
         settle    <= '0;
         ch        <= '0;
         work_bank <= '{default: '0};
         out_bank  <= '{default: '0};
      end else begin
         state  <= nxt;
         timer  <= (!en || timer == P_LAST) ? '0 : timer + 1'b1;
         settle <= state == SETTLE ? settle + 1'b1 : '0;
         ch     <= done && !last ? ch + 1'b1 : (state == IDLE || state == SETTLE) ? '0 : ch;
         if (done && state == WAIT) work_bank[ch] <= wr_val;
         if (IR_vld) out_bank <= work_bank;
      end
   assign IR_en  = state inside {SETTLE, REQ, WAIT, DONE};
   assign IR_vld = en && state == DONE;
   assign IR_val = {1'b0, sel} < N_CH ? out_bank[sel] : '0;
endmodule
